fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It issues read requests to the FIFO, uses the FIFO's registered underflow flag to qualify each returned byte, and packs the accepted bytes into a wide word. Each word is offered to downstream logic over a valid/ready handshake.

## Interface
- `WORDSIZE`, default 8: FIFO data width in bits.
- `PACK`, default 4: FIFO words per output word; legal range 2–8.
- `TIMEOUT`, default 16: number of consecutive empty responses before a partial word is flushed. Used only with `PACKER_TIMEOUT_EN`. Legal range 1–255.
- `rd_clk`  in  1: read-domain clock. All logic is posedge.
- `init`  in  1: reset. Asynchronous and active-high. Already decided.
- `fifo_data`  in  WORDSIZE: FIFO `data_out`.
- `fifo_underflow`  in  1: FIFO registered underflow flag.
- `fifo_read_en`  out  1: read request to the FIFO. Registered.
- `m_data`  out  WORDSIZE*PACK: packed word. The first byte received sits in bits [WORDSIZE-1:0], i.e. little-endian.
- `m_keep`  out  PACK: byte-lane valid mask.
- `m_valid`  out  1: packed word available.
- `m_ready`  in  1: downstream accepts the word.

## Operation
- **Read response convention.** When `fifo_read_en` is high in cycle N, the FIFO response is sampled in cycle N+1:
  - `fifo_underflow`=0: `fifo_data` is a valid byte.
  - `fifo_underflow`=1: the read was empty, and `fifo_data` must be ignored.
- **Registers.**
  - `byte_cnt`: 0..PACK, counts bytes captured into the current word.
  - `rd_pend`: equals the previous cycle's `fifo_read_en`.
  - `shreg`: assembly register.
- **FILL state:**
  - `fifo_read_en` is set to 1 for the next cycle iff `byte_cnt + rd_pend < PACK`.
    - This allows back-to-back reads.
    - A word is never over-fetched; at most one read is outstanding.
  - If `rd_pend`=1 and `fifo_underflow`=0: write `fifo_data` into lane `byte_cnt` and increment `byte_cnt`.
  - When the incremented `byte_cnt` reaches PACK, go to HOLD.
- **HOLD state:**
  - `m_valid`=1, `fifo_read_en`=0.
  - `m_data` and `m_keep` are stable until the handshake.
  - On `m_valid & m_ready`: clear `byte_cnt` and the lanes, then go to FILL.
- **Full word.** `m_keep` is all ones.
- **Reset.** `init` asserted at any time, including mid-word or in HOLD:
  - State goes to FILL.
  - `byte_cnt`=0, `rd_pend`=0, `shreg`=0.
  - Outputs: `fifo_read_en`=0, `m_valid`=0, `m_data`=0, `m_keep`=0.
  - Any partially assembled bytes are discarded.
- **FIFO empty at startup.** The block keeps polling with one read per cycle. Each empty response is discarded.

## Timing
- **Throughput.** For a non-empty FIFO and `m_ready` held at 1, starting from FILL with `byte_cnt`=0:
  - Reads are issued in cycles 0..PACK-1.
  - The last byte is captured in cycle PACK.
  - `m_valid`=1 in cycle PACK+1.
  - FILL resumes in cycle PACK+2.
  - Sustained rate is one word per PACK+2 cycles.
- **Backpressure.** `m_ready`=0 holds HOLD indefinitely. No reads are issued during HOLD.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`PACKER_TIMEOUT_EN` defined:**
  - An idle counter increments on each empty response (`rd_pend & fifo_underflow`) while 0 < `byte_cnt` < PACK.
  - It clears on any captured byte and on reset.
  - When it reaches TIMEOUT, go to HOLD with the partial word: `m_keep` = one bit per captured lane, low lanes first; unused lanes read zero.
  - An in-flight read at that moment is still honoured. If its response is a valid byte, it is captured before HOLD, so no data is lost.
- **`PACKER_TIMEOUT_EN` undefined:**
  - Words are emitted only when full, and `m_keep` is always all ones.
  - The counter logic is absent.

## Structure
- Shared package `fifo_pkg`:
  - Constants: `WORDSIZE`, `PTR_SIZE`, `QSIZE`, `PACK`.
  - Typedef `pack_state_t` with values {FILL, HOLD}.
- One sub-module, `pack_idle_timer`:
  - Contains the idle counter and terminal-count compare.
  - Instantiated only under `PACKER_TIMEOUT_EN`.

## Test plan
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44 and `m_ready`=1 → `m_data`=0x44332211, `m_keep`=0xF, `m_valid` pulse exactly once, in cycle 5 after the first read.
- FIFO empty for 20 cycles, then 0xA0..0xA3 written → reads issue every cycle, no capture while underflow=1, then `m_data`=0xA3A2A1A0.
- `m_ready`=0 for 10 cycles with 8 bytes available → `m_data` holds the first word, `fifo_read_en`=0 throughout, and the second word follows correctly after release.
- `init` pulsed after 2 bytes captured → all outputs 0 and `byte_cnt`=0; the next 4 bytes form a fresh word.
- With `PACKER_TIMEOUT_EN` and TIMEOUT=16: write 0x5A,0x6B, then nothing → after 16 empty responses, `m_data`=0x00006B5A and `m_keep`=0x3.
- Without `PACKER_TIMEOUT_EN`: same stimulus → `m_valid` stays 0 for 200 cycles.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO and its read-side packer.
package fifo_pkg;

   localparam int WORDSIZE = 8;
   localparam int PTR_SIZE = 4;
   localparam int QSIZE    = 1 << PTR_SIZE;
   localparam int PACK     = 4;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_t;

endpackage

// File: rtl/pack_idle_timer.sv
// Idle timer for the read packer: down-counts empty FIFO responses while a
// partial word is being assembled; expired flags the terminal count.
module pack_idle_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic rd_clk,
   input  logic init,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [7:0] remain;

   // Reload on clear, otherwise step down once per empty response and stick at zero.
   always_ff @(posedge rd_clk or posedge init) begin
      if (init) begin
         remain <= 8'(TIMEOUT);
      end else if (clr) begin
         remain <= 8'(TIMEOUT);
      end else if (inc && (remain != 8'd0)) begin
         remain <= remain - 8'd1;
      end
   end

   assign expired = (remain == 8'd0);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: issues reads, qualifies each response with the
// registered underflow flag and packs accepted bytes little-endian into a
// PACK-lane word offered on a valid/ready handshake.
// Optional feature macro: PACKER_TIMEOUT_EN (flush a partial word after
// TIMEOUT consecutive empty responses).
//
// state | meaning
// FILL  | issuing reads and capturing bytes into shreg
// HOLD  | word presented on m_data/m_keep, waiting for m_ready
module fifo_rd_packer #(
   parameter int WORDSIZE = fifo_pkg::WORDSIZE,
   parameter int PACK     = fifo_pkg::PACK,
   parameter int TIMEOUT  = 16
) (
   input  logic                     rd_clk,
   input  logic                     init,
   input  logic [WORDSIZE-1:0]      fifo_data,
   input  logic                     fifo_underflow,
   output logic                     fifo_read_en,
   output logic [WORDSIZE*PACK-1:0] m_data,
   output logic [PACK-1:0]          m_keep,
   output logic                     m_valid,
   input  logic                     m_ready
);

   import fifo_pkg::*;

   localparam int CW = $clog2(PACK + 1);

   pack_state_t              state, state_nx;
   logic [CW-1:0]            byte_cnt, byte_cnt_nx;
   logic                     rd_pend;
   logic [WORDSIZE*PACK-1:0] shreg, shreg_nx;
   logic [PACK-1:0]          keep_nx;
   logic                     valid_nx;
   logic                     read_en_nx;
   logic                     capture;
   logic                     tmr_expired;

`ifdef PACKER_TIMEOUT_EN
   pack_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .rd_clk  (rd_clk),
      .init    (init),
      .clr     (capture || ((state == HOLD) && m_ready)),
      .inc     ((state == FILL) && rd_pend && fifo_underflow &&
                (byte_cnt != '0) && (byte_cnt < CW'(PACK))),
      .expired (tmr_expired)
   );
`else
   assign tmr_expired = 1'b0;
`endif

   assign m_data = shreg;

   // State, counters and all outputs are registered; reset discards any partial word.
   always_ff @(posedge rd_clk or posedge init) begin
      if (init) begin
         state        <= FILL;
         byte_cnt     <= '0;
         rd_pend      <= 1'b0;
         shreg        <= '0;
         fifo_read_en <= 1'b0;
         m_valid      <= 1'b0;
         m_keep       <= '0;
      end else begin
         state        <= state_nx;
         byte_cnt     <= byte_cnt_nx;
         rd_pend      <= fifo_read_en;
         shreg        <= shreg_nx;
         fifo_read_en <= read_en_nx;
         m_valid      <= valid_nx;
         m_keep       <= keep_nx;
      end
   end

   // Capture/advance logic. The read decision counts the byte just captured
   // plus the read issued this cycle, so the word is never over-fetched.
   // A timeout flush waits until no read is in flight so its byte is kept.
   always_comb begin
      state_nx    = state;
      byte_cnt_nx = byte_cnt;
      shreg_nx    = shreg;
      keep_nx     = m_keep;
      valid_nx    = m_valid;
      read_en_nx  = 1'b0;
      capture     = 1'b0;
      case (state)
         FILL: begin
            capture = rd_pend && !fifo_underflow;
            if (capture) begin
               for (int i = 0; i < PACK; i++) begin
                  if (byte_cnt == CW'(i)) begin
                     shreg_nx[i*WORDSIZE +: WORDSIZE] = fifo_data;
                  end
               end
               byte_cnt_nx = byte_cnt + CW'(1);
            end
            if ((byte_cnt_nx == CW'(PACK)) || (tmr_expired && !fifo_read_en)) begin
               state_nx = HOLD;
               valid_nx = 1'b1;
               for (int i = 0; i < PACK; i++) begin
                  keep_nx[i] = (CW'(i) < byte_cnt_nx);
               end
            end else begin
               read_en_nx = !tmr_expired &&
                  (({1'b0, byte_cnt_nx} + (CW+1)'(fifo_read_en)) < (CW+1)'(PACK));
            end
         end
         HOLD: begin
            if (m_ready) begin
               state_nx    = FILL;
               byte_cnt_nx = '0;
               shreg_nx    = '0;
               keep_nx     = '0;
               valid_nx    = 1'b0;
               read_en_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = FILL;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a queue-based FIFO model answers reads one
// cycle later; expected words are built from the byte stream and checked by
// an independent monitor whenever m_valid is high.
module tb_fifo_rd_packer;

   localparam int WS = 8;
   localparam int PK = 4;
   localparam int TO = 16;

   logic             rd_clk = 1'b0;
   logic             init = 1'b1;
   logic [WS-1:0]    fifo_data = '0;
   logic             fifo_underflow = 1'b0;
   logic             fifo_read_en;
   logic [WS*PK-1:0] m_data;
   logic [PK-1:0]    m_keep;
   logic             m_valid;
   logic             m_ready = 1'b0;

   fifo_rd_packer #(
      .WORDSIZE (WS),
      .PACK     (PK),
      .TIMEOUT  (TO)
   ) dut (
      .rd_clk         (rd_clk),
      .init           (init),
      .fifo_data      (fifo_data),
      .fifo_underflow (fifo_underflow),
      .fifo_read_en   (fifo_read_en),
      .m_data         (m_data),
      .m_keep         (m_keep),
      .m_valid        (m_valid),
      .m_ready        (m_ready)
   );

   always #5 rd_clk = ~rd_clk;

   typedef struct {
      logic [WS*PK-1:0] data;
      logic [PK-1:0]    keep;
   } exp_t;

   exp_t          exp_q[$];
   logic [WS-1:0] fifo_q[$];
   logic [WS-1:0] acc[$];
   int            hs_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int popped = 0;
   bit rnd_mode = 0;
   bit arm = 0;
   int first_rd = -1;
   int first_valid = -1;
   bit count_en = 0;
   int rd_cnt = 0;
   int valid_cnt = 0;
   logic [WS*PK-1:0] last_data = '0;
   logic [PK-1:0]    last_keep = '0;

   always @(posedge rd_clk) cyc++;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: every PK bytes written to the FIFO form one word, first byte lowest.
   task automatic emit_acc();
      exp_t e;
      e.data = '0;
      e.keep = '0;
      foreach (acc[i]) begin
         e.data = e.data | ((WS*PK)'(acc[i]) << (WS*i));
         e.keep[i] = 1'b1;
      end
      exp_q.push_back(e);
      acc.delete();
   endtask

   task automatic push_byte(input logic [WS-1:0] b);
      fifo_q.push_back(b);
      acc.push_back(b);
      if (acc.size() == PK) emit_acc();
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge rd_clk);
      #1;
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (popped < n && k < budget) begin
         @(posedge rd_clk);
         k++;
      end
      #1;
      chk("wait_words", popped, n);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!m_valid && k < budget) begin
         @(posedge rd_clk);
         #1;
         k++;
      end
      chk("wait_valid", m_valid, 1);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge rd_clk);
         k++;
      end
      #1;
      chk("drain_left", exp_q.size(), 0);
   endtask

   // FIFO model: a read seen in one cycle is answered just after the next edge.
   initial begin
      logic req;
      forever begin
         @(negedge rd_clk);
         req = fifo_read_en;
         @(posedge rd_clk);
         #1;
         if (req) begin
            if (fifo_q.size() > 0) begin
               fifo_data = fifo_q.pop_front();
               fifo_underflow = 1'b0;
            end else begin
               fifo_data = WS'($urandom);
               fifo_underflow = 1'b1;
            end
         end
      end
   end

   // Random backpressure during the random phase.
   initial begin
      forever begin
         @(posedge rd_clk);
         #1;
         if (rnd_mode) m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compare every presented word against the scoreboard head.
   always @(negedge rd_clk) begin
      if (arm) begin
         if (fifo_read_en && first_rd < 0) first_rd = cyc;
         if (m_valid && first_valid < 0) first_valid = cyc;
      end
      if (count_en) begin
         rd_cnt += int'(fifo_read_en);
         valid_cnt += int'(m_valid);
      end
      if (m_valid) begin
         chk("read_en_in_hold", fifo_read_en, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_word", m_data, 0);
            if (m_ready) popped++;
         end else begin
            chk("m_data", m_data, exp_q[0].data);
            chk("m_keep", m_keep, exp_q[0].keep);
            if (m_ready) begin
               last_data = m_data;
               last_keep = m_keep;
               void'(exp_q.pop_front());
               popped++;
               hs_q.push_back(cyc);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge rd_clk);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      init = 1'b1;
      m_ready = 1'b1;
      cycles(3);
      chk("rst_read_en", fifo_read_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_keep", m_keep, 0);

      // Preloaded FIFO, downstream always ready.
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      arm = 1;
      init = 1'b0;
      wait_words(1, 40);
      cycles(10);
      chk("a_latency", first_valid - first_rd, PK + 1);
      chk("a_word_count", popped, 1);
      chk("a_data", last_data, 32'h44332211);
      arm = 0;

      // Empty FIFO: one poll per cycle, nothing captured.
      rd_cnt = 0;
      valid_cnt = 0;
      count_en = 1;
      cycles(20);
      count_en = 0;
      chk("b_poll_reads", rd_cnt, 20);
      chk("b_no_valid", valid_cnt, 0);
      for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
      wait_words(2, 40);
      chk("b_data", last_data, 32'hA3A2A1A0);

      // Backpressure with two words available.
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_byte(WS'($urandom));
      wait_valid(40);
      rd_cnt = 0;
      valid_cnt = 0;
      count_en = 1;
      cycles(10);
      count_en = 0;
      chk("c_reads_in_hold", rd_cnt, 0);
      chk("c_valid_held", valid_cnt, 10);
      m_ready = 1'b1;
      wait_words(4, 60);
      chk("c_word_period", hs_q[3] - hs_q[2], PK + 2);

      // Reset in the middle of a word.
      push_byte(8'hC1);
      push_byte(8'hC2);
      cycles(10);
      init = 1'b1;
      @(negedge rd_clk);
      chk("d_rst_read_en", fifo_read_en, 0);
      chk("d_rst_valid", m_valid, 0);
      chk("d_rst_data", m_data, 0);
      chk("d_rst_keep", m_keep, 0);
      acc.delete();
      cycles(1);
      init = 1'b0;
      for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
      wait_words(5, 40);
      chk("d_fresh_word", last_data, 32'hD3D2D1D0);

      // Two bytes, then silence.
      push_byte(8'h5A);
      push_byte(8'h6B);
`ifdef PACKER_TIMEOUT_EN
      emit_acc();
      wait_words(6, 100);
      chk("e_partial_data", last_data, 32'h00006B5A);
      chk("e_partial_keep", last_keep, 4'h3);
`else
      valid_cnt = 0;
      count_en = 1;
      cycles(200);
      count_en = 0;
      chk("e_no_flush", valid_cnt, 0);
      init = 1'b1;
      cycles(1);
      acc.delete();
      init = 1'b0;
`endif

      // Random bytes, random gaps, random backpressure.
      rnd_mode = 1;
      for (int i = 0; i < 48; i++) begin
         push_byte(WS'($urandom));
         cycles($urandom_range(0, 3));
      end
      wait_drain(600);
      rnd_mode = 0;
      m_ready = 1'b1;
      cycles(10);
      chk("end_fifo_empty", fifo_q.size(), 0);
      chk("end_scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
